icache_ctrl: RTL and testbench
==============================

// Module: icache_ctrl
// PURPOSE
//  Read-only, direct-mapped instruction cache that answers the fetch stage's PC lookups.
//  Hit: returns the word combinationally with stall=0.
//  Miss: holds stall=1 and fills the whole block from pipelined main memory, then serves the original lookup.
//  Sits between the fetch PC/instr path and the multi-cycle memory.
// PARAMETERS
//  BLOCK_WORDS  8   16-bit words per block (offset = addr[3:1])
//  NUM_BLOCKS   32  cache lines (index = addr[8:4]; tag = addr[15:9])
//  MEM_LATENCY  4   cycles from mem_rd to mem_valid; bench-only, RTL counts mem_valid pulses
// PORTS
//  clk          in   1   clock, rising edge
//  rst          in   1   asynchronous, active-high reset
//  op           in   1   lookup enable; 0 = no access, never misses
//  address_in   in   16  byte address; bit 0 ignored
//  data_out     out  16  instruction word at address_in
//  stall        out  1   1 = data_out invalid, requester must hold/squash
//  mem_addr     out  16  word address of current fill request
//  mem_rd       out  1   fill request strobe, one word per cycle
//  mem_data     in   16  returned fill word
//  mem_valid    in   1   mem_data valid; words return in request order
// BEHAVIOUR
//  Clock/reset: one clock; reset is asynchronous and active-high.
//  Reset:
//   - state=IDLE; all valid bits=0; req_cnt=rcv_cnt=0.
//   - While rst=1: mem_rd=0, mem_addr=0, stall=0, data_out=0.
//   - Tag/data arrays are not reset.
//  Lookup (comb.): hit = op & valid[index] & (tag_arr[index]==tag) & state==IDLE.
//   - data_out = hit ? word[index][offset] : 16'h0000.
//   - stall = op & ~hit; also 1 in every FILL cycle regardless of op.
//  FSM IDLE -> FILL on clock edge when op & ~hit.
//   - Latch fill_tag/fill_index from address_in on that edge; clear valid[fill_index].
//  FILL:
//   - mem_rd=1 while req_cnt<BLOCK_WORDS.
//   - mem_addr = {fill_tag, fill_index, req_cnt[2:0], 1'b0}; req_cnt++ per request.
//   - Each mem_valid: write mem_data to word[fill_index][rcv_cnt]; rcv_cnt++.
//   - Edge where rcv_cnt==BLOCK_WORDS-1 and mem_valid: write tag, set valid, clear counters, go to IDLE.
//   - Next cycle re-looks up address_in (hit if unchanged).
//  Latency: miss with MEM_LATENCY=L, 8 words -> stall high for 1+8+L cycles (13 at L=4).
//   Returned word is available the following cycle.
//  Boundaries:
//   - address_in change during FILL (branch redirect): the fill completes for the latched block.
//     The new address is looked up on return to IDLE (may miss again).
//   - op dropped during FILL: fill still completes.
//   - Conflict eviction (same index, new tag) overwrites the line; there is no dirty state.
//   - mem_valid outside FILL, or beyond 8 words: ignored.
//   - rst mid-FILL: abort immediately; mem_rd=0; partial line stays invalid.
//   - Counters are 4 bits; they never wrap past BLOCK_WORDS.
// STRUCTURE
//  Shared package/header cache_defs:
//   - field widths TAG_W=7, IDX_W=5, OFF_W=3
//   - state encoding IDLE=1'b0, FILL=1'b1
//  One sub-module: icache_array (tag+valid+data storage; comb. read, sync write, async valid clear).
//  FSM and counters in icache_ctrl.
// TESTING
//  1. Cold miss at 0x0000 (L=4, memory returns 0xA000+word index):
//     stall=1 for 13 cycles; mem_addr 0x0000..0x000E on 8 consecutive cycles; then data_out=0xA000, stall=0.
//  2. After fill, address_in=0x0006 -> same-cycle data_out=0xA003, stall=0, mem_rd=0.
//  3. 0x0200 (index 0, tag 1): miss and evict; fill from 0x0200..0x020E.
//     Then 0x0000 misses again (13-cycle stall).
//  4. Change address_in to 0x0040 at cycle 5 of a 0x0000 fill:
//     all 8 0x0000 words still filled; then second miss fills 0x0040..0x004E.
//  5. Assert rst at cycle 6 of a fill: mem_rd=0 same cycle.
//     After release, 0x0000 misses (valid clear) and refills fully.
//  6. op=0 with uncached address 0x1234: stall=0, mem_rd=0 indefinitely; spurious mem_valid causes no array write.

Source files
------------

// File: rtl/icache_ctrl_pkg.sv
// Shared field widths, geometry and FSM encoding for the direct-mapped instruction cache.
// Address split: tag = addr[15:9], index = addr[8:4], word offset = addr[3:1].
package icache_ctrl_pkg;

    localparam int WORD_W      = 16;
    localparam int ADDR_W      = 16;
    localparam int TAG_W       = 7;
    localparam int IDX_W       = 5;
    localparam int OFF_W       = 3;
    localparam int BLOCK_WORDS = 8;
    localparam int NUM_BLOCKS  = 32;
    localparam int CNT_W       = 4;

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } state_t;

    function automatic logic [TAG_W-1:0] addr_tag(input logic [ADDR_W-1:0] a);
        return a[ADDR_W-1 -: TAG_W];
    endfunction

    function automatic logic [IDX_W-1:0] addr_idx(input logic [ADDR_W-1:0] a);
        return a[OFF_W+IDX_W -: IDX_W];
    endfunction

    function automatic logic [OFF_W-1:0] addr_off(input logic [ADDR_W-1:0] a);
        return a[OFF_W:1];
    endfunction

endpackage

// File: rtl/icache_ctrl_if.sv
// Fetch-side lookup and memory-side fill signals of the instruction cache.
// slave = cache view, master = fetch stage / memory view.
interface icache_ctrl_if;
    import icache_ctrl_pkg::*;

    logic              op;
    logic [ADDR_W-1:0] address_in;
    logic [WORD_W-1:0] data_out;
    logic              stall;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd;
    logic [WORD_W-1:0] mem_data;
    logic              mem_valid;

    modport slave (
        input  op, address_in, mem_data, mem_valid,
        output data_out, stall, mem_addr, mem_rd
    );

    modport master (
        output op, address_in, mem_data, mem_valid,
        input  data_out, stall, mem_addr, mem_rd
    );

endinterface

// File: rtl/icache_array.sv
// Tag, valid and data storage: combinational read, synchronous write, valid bits cleared by reset.
// Tag and data contents are intentionally left unreset.
module icache_array
    import icache_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [IDX_W-1:0]  i_rd_idx,
    input  logic [OFF_W-1:0]  i_rd_off,
    output logic              o_rd_valid,
    output logic [TAG_W-1:0]  o_rd_tag,
    output logic [WORD_W-1:0] o_rd_word,
    input  logic              i_inv,
    input  logic [IDX_W-1:0]  i_inv_idx,
    input  logic              i_wr_word,
    input  logic              i_wr_tag,
    input  logic [IDX_W-1:0]  i_wr_idx,
    input  logic [OFF_W-1:0]  i_wr_off,
    input  logic [WORD_W-1:0] i_wr_data,
    input  logic [TAG_W-1:0]  i_wr_tag_val
);

    logic [NUM_BLOCKS-1:0] r_valid;
    logic [TAG_W-1:0]      r_tag  [NUM_BLOCKS];
    logic [WORD_W-1:0]     r_data [NUM_BLOCKS*BLOCK_WORDS];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= '0;
        end else begin
            if (i_inv)
                r_valid[i_inv_idx] <= 1'b0;
            if (i_wr_tag)
                r_valid[i_wr_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (i_wr_tag)
            r_tag[i_wr_idx] <= i_wr_tag_val;
        if (i_wr_word)
            r_data[{i_wr_idx, i_wr_off}] <= i_wr_data;
    end

    assign o_rd_valid = r_valid[i_rd_idx];
    assign o_rd_tag   = r_tag[i_rd_idx];
    assign o_rd_word  = r_data[{i_rd_idx, i_rd_off}];

endmodule

// File: rtl/icache_ctrl.sv
// Direct-mapped read-only instruction cache controller: combinational hit path,
// block fill from a pipelined memory on miss, stall held until the line is valid.
module icache_ctrl
    import icache_ctrl_pkg::*;
(
    input logic          clk,
    input logic          rst,
    icache_ctrl_if.slave bus
);

    state_t            r_state, w_state_nxt;
    logic [TAG_W-1:0]  r_fill_tag, w_fill_tag_nxt;
    logic [IDX_W-1:0]  r_fill_idx, w_fill_idx_nxt;
    logic [CNT_W-1:0]  r_req_cnt, w_req_cnt_nxt;
    logic [CNT_W-1:0]  r_rcv_cnt, w_rcv_cnt_nxt;

    logic [TAG_W-1:0]  w_tag;
    logic [IDX_W-1:0]  w_idx;
    logic [OFF_W-1:0]  w_off;
    logic              w_rd_valid;
    logic [TAG_W-1:0]  w_rd_tag;
    logic [WORD_W-1:0] w_rd_word;
    logic              w_hit;
    logic              w_inv;
    logic              w_wr_word;
    logic              w_wr_tag;
    logic              w_mem_rd;
    logic              w_unused_addr0;

    assign w_tag          = addr_tag(bus.address_in);
    assign w_idx          = addr_idx(bus.address_in);
    assign w_off          = addr_off(bus.address_in);
    assign w_unused_addr0 = bus.address_in[0];

    icache_array u_array (
        .clk          (clk),
        .rst          (rst),
        .i_rd_idx     (w_idx),
        .i_rd_off     (w_off),
        .o_rd_valid   (w_rd_valid),
        .o_rd_tag     (w_rd_tag),
        .o_rd_word    (w_rd_word),
        .i_inv        (w_inv),
        .i_inv_idx    (w_idx),
        .i_wr_word    (w_wr_word),
        .i_wr_tag     (w_wr_tag),
        .i_wr_idx     (r_fill_idx),
        .i_wr_off     (r_rcv_cnt[OFF_W-1:0]),
        .i_wr_data    (bus.mem_data),
        .i_wr_tag_val (r_fill_tag)
    );

    // Lookups only hit in IDLE so a redirected PC never sees a half-filled line.
    assign w_hit = bus.op & w_rd_valid & (w_rd_tag == w_tag) & (r_state == IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_fill_tag <= '0;
            r_fill_idx <= '0;
            r_req_cnt  <= '0;
            r_rcv_cnt  <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_fill_tag <= w_fill_tag_nxt;
            r_fill_idx <= w_fill_idx_nxt;
            r_req_cnt  <= w_req_cnt_nxt;
            r_rcv_cnt  <= w_rcv_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_fill_tag_nxt = r_fill_tag;
        w_fill_idx_nxt = r_fill_idx;
        w_req_cnt_nxt  = r_req_cnt;
        w_rcv_cnt_nxt  = r_rcv_cnt;
        w_inv          = 1'b0;
        w_wr_word      = 1'b0;
        w_wr_tag       = 1'b0;
        w_mem_rd       = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.op && !w_hit) begin
                    w_state_nxt    = FILL;
                    w_fill_tag_nxt = w_tag;
                    w_fill_idx_nxt = w_idx;
                    w_inv          = 1'b1;
                end
            end
            FILL: begin
                if (r_req_cnt < CNT_W'(BLOCK_WORDS)) begin
                    w_mem_rd      = 1'b1;
                    w_req_cnt_nxt = r_req_cnt + 1'b1;
                end
                // Words beyond the block are dropped; the last one also commits the tag.
                if (bus.mem_valid && (r_rcv_cnt < CNT_W'(BLOCK_WORDS))) begin
                    w_wr_word     = 1'b1;
                    w_rcv_cnt_nxt = r_rcv_cnt + 1'b1;
                    if (r_rcv_cnt == CNT_W'(BLOCK_WORDS - 1)) begin
                        w_wr_tag      = 1'b1;
                        w_req_cnt_nxt = '0;
                        w_rcv_cnt_nxt = '0;
                        w_state_nxt   = IDLE;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign bus.data_out = w_hit ? w_rd_word : '0;
    assign bus.stall    = ~rst & ((bus.op & ~w_hit) | (r_state == FILL));
    assign bus.mem_rd   = w_mem_rd;
    assign bus.mem_addr = (r_state == FILL) ?
                          {r_fill_tag, r_fill_idx, r_req_cnt[OFF_W-1:0], 1'b0} : '0;

endmodule

// File: tb/tb_icache_ctrl.sv
// Directed bench for icache_ctrl: 4-cycle pipelined memory model returning 0xA000 + word address,
// hand-written miss/redirect/reset/spurious sequences and a table of combinational lookups.
module tb_icache_ctrl;

    logic clk;
    logic rst;

    icache_ctrl_if bus_if ();

    icache_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: request sampled at an edge appears as mem_valid 4 cycles after it was issued.
    logic [4:1]  rd_d;
    logic [15:0] a_d [1:4];
    logic        spur_vld;
    logic [15:0] spur_data;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_d <= '0;
            for (int i = 1; i <= 4; i++) a_d[i] <= '0;
        end else begin
            rd_d   <= {rd_d[3:1], bus_if.mem_rd};
            a_d[1] <= bus_if.mem_addr;
            for (int i = 2; i <= 4; i++) a_d[i] <= a_d[i-1];
        end
    end

    assign bus_if.mem_valid = rd_d[4] | spur_vld;
    assign bus_if.mem_data  = spur_vld ? spur_data : (16'hA000 + {1'b0, a_d[4][15:1]});

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic        op;
        logic [15:0] addr;
        logic [15:0] data;
        logic        stall;
        logic        rd;
    } vec_t;

    vec_t vecs [8];

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return 16'hA000 + {1'b0, a[15:1]};
    endfunction

    function automatic logic [15:0] blk(input logic [15:0] a);
        return {a[15:4], 4'h0};
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issues a lookup that misses and follows it until stall drops, checking every fill request address.
    task automatic do_miss(input logic [15:0] addr, input int redir_cyc, input logic [15:0] redir_addr,
                           input int exp_cycles, input int exp_reqs);
        int          cnt;
        int          nreq;
        logic [15:0] exp_a;
        logic [15:0] fin;
        cnt  = 0;
        nreq = 0;
        fin  = addr;
        bus_if.address_in = addr;
        bus_if.op         = 1'b1;
        #1;
        while (bus_if.stall && cnt < 100) begin
            if (cnt == redir_cyc) begin
                bus_if.address_in = redir_addr;
                fin = redir_addr;
                #1;
            end
            if (bus_if.mem_rd) begin
                exp_a = (nreq < 8) ? blk(addr) + 16'(2 * nreq) : blk(redir_addr) + 16'(2 * (nreq - 8));
                chk("mem_addr", bus_if.mem_addr, exp_a);
                nreq++;
            end
            cnt++;
            step();
        end
        chk("stall_cycles", 16'(cnt), 16'(exp_cycles));
        chk("fill_requests", 16'(nreq), 16'(exp_reqs));
        chk("data_after_fill", bus_if.data_out, mem_word(fin));
        chk("stall_after_fill", 16'(bus_if.stall), 16'd0);
    endtask

    initial begin
        vecs[0] = '{op: 1'b1, addr: 16'h0006, data: 16'hA003, stall: 1'b0, rd: 1'b0};
        vecs[1] = '{op: 1'b1, addr: 16'h000E, data: 16'hA007, stall: 1'b0, rd: 1'b0};
        vecs[2] = '{op: 1'b1, addr: 16'h0001, data: 16'hA000, stall: 1'b0, rd: 1'b0};
        vecs[3] = '{op: 1'b1, addr: 16'h0042, data: 16'hA021, stall: 1'b0, rd: 1'b0};
        vecs[4] = '{op: 1'b1, addr: 16'h004E, data: 16'hA027, stall: 1'b0, rd: 1'b0};
        vecs[5] = '{op: 1'b1, addr: 16'h0200, data: 16'h0000, stall: 1'b1, rd: 1'b0};
        vecs[6] = '{op: 1'b1, addr: 16'h0010, data: 16'h0000, stall: 1'b1, rd: 1'b0};
        vecs[7] = '{op: 1'b0, addr: 16'h0040, data: 16'h0000, stall: 1'b0, rd: 1'b0};

        rst               = 1'b1;
        spur_vld          = 1'b0;
        spur_data         = 16'h0000;
        bus_if.op         = 1'b1;
        bus_if.address_in = 16'h0000;
        #2;
        chk("rst_stall", 16'(bus_if.stall), 16'd0);
        chk("rst_data", bus_if.data_out, 16'h0000);
        chk("rst_mem_rd", 16'(bus_if.mem_rd), 16'd0);
        chk("rst_mem_addr", bus_if.mem_addr, 16'h0000);
        step();
        step();
        bus_if.op = 1'b0;
        rst       = 1'b0;
        step();

        // Cold miss, then same-cycle hit on another word of the block.
        do_miss(16'h0000, -1, 16'h0000, 13, 8);
        bus_if.address_in = 16'h0006;
        #1;
        chk("hit_data", bus_if.data_out, 16'hA003);
        chk("hit_stall", 16'(bus_if.stall), 16'd0);
        chk("hit_mem_rd", 16'(bus_if.mem_rd), 16'd0);
        step();

        // Conflict eviction and re-miss of the evicted block.
        do_miss(16'h0200, -1, 16'h0000, 13, 8);
        do_miss(16'h0000, -1, 16'h0000, 13, 8);

        // Reset in the middle of a fill.
        do_miss(16'h0200, -1, 16'h0000, 13, 8);
        bus_if.address_in = 16'h0000;
        bus_if.op         = 1'b1;
        for (int i = 0; i < 6; i++) step();
        chk("rd_before_rst", 16'(bus_if.mem_rd), 16'd1);
        rst = 1'b1;
        #1;
        chk("rd_in_rst", 16'(bus_if.mem_rd), 16'd0);
        chk("stall_in_rst", 16'(bus_if.stall), 16'd0);
        chk("addr_in_rst", bus_if.mem_addr, 16'h0000);
        step();
        step();
        step();
        rst = 1'b0;
        #1;
        do_miss(16'h0000, -1, 16'h0000, 13, 8);

        // Branch redirect during a fill: old block completes, new block fills afterwards.
        do_miss(16'h0200, -1, 16'h0000, 13, 8);
        do_miss(16'h0000, 5, 16'h0040, 26, 16);

        for (int i = 0; i < 8; i++) begin
            bus_if.op         = vecs[i].op;
            bus_if.address_in = vecs[i].addr;
            #1;
            chk($sformatf("vec%0d_data", i), bus_if.data_out, vecs[i].data);
            chk($sformatf("vec%0d_stall", i), 16'(bus_if.stall), 16'(vecs[i].stall));
            chk($sformatf("vec%0d_rd", i), 16'(bus_if.mem_rd), 16'(vecs[i].rd));
            bus_if.op = 1'b0;
            step();
        end

        // op=0 on an uncached address with spurious memory responses.
        bus_if.op         = 1'b0;
        bus_if.address_in = 16'h1234;
        for (int i = 0; i < 12; i++) begin
            spur_vld  = (i >= 3 && i < 9);
            spur_data = 16'hDEAD;
            #1;
            chk($sformatf("idle_stall%0d", i), 16'(bus_if.stall), 16'd0);
            chk($sformatf("idle_rd%0d", i), 16'(bus_if.mem_rd), 16'd0);
            step();
        end
        spur_vld          = 1'b0;
        bus_if.op         = 1'b1;
        bus_if.address_in = 16'h0040;
        #1;
        chk("spur_keep_0040", bus_if.data_out, 16'hA020);
        bus_if.address_in = 16'h0000;
        #1;
        chk("spur_keep_0000", bus_if.data_out, 16'hA000);
        bus_if.address_in = 16'h1234;
        #1;
        chk("uncached_1234_stall", 16'(bus_if.stall), 16'd1);
        bus_if.op = 1'b0;
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
